// File: rtl/cond_logic_pkg.sv
// cond_logic_pkg: condition codes and flag bit positions for the condition unit
package cond_pkg;
  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/cond_logic_if.sv
// cond_logic_if: decoder/ALU-side bundle into the condition unit and its committed strobes
interface cond_logic_if #(parameter int CNT_W = 32);
  logic             InstrValid;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             NoWrite;
  logic             CondEx;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] ExecCnt;
  logic [CNT_W-1:0] SquashCnt;
  modport master (
    output InstrValid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    input  CondEx, PCSrc, RegWrite, MemWrite, Flags, ExecCnt, SquashCnt
  );
  modport slave (
    input  InstrValid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    output CondEx, PCSrc, RegWrite, MemWrite, Flags, ExecCnt, SquashCnt
  );
endinterface

// File: rtl/cond_logic_check.sv
// cond_check: combinational ARM condition evaluation of a condition field against {N,Z,C,V}
module cond_check
  import cond_pkg::*;
(
  input  cond_e      cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);
  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];
  // NV is treated as never-execute so it squashes rather than acting as AL
  always_comb begin
    case (cond)
      EQ:      cond_ex = z;
      NE:      cond_ex = ~z;
      CS:      cond_ex = c;
      CC:      cond_ex = ~c;
      MI:      cond_ex = n;
      PL:      cond_ex = ~n;
      VS:      cond_ex = v;
      VC:      cond_ex = ~v;
      HI:      cond_ex = c & ~z;
      LS:      cond_ex = ~c | z;
      GE:      cond_ex = n == v;
      LT:      cond_ex = n != v;
      GT:      cond_ex = ~z & (n == v);
      LE:      cond_ex = z | (n != v);
      AL:      cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
endmodule

// File: rtl/cond_logic.sv
// cond_logic: flag register, condition check and write-strobe gating; COND_PERF_EN adds exec/squash counters
module cond_logic
  import cond_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic         clk,
  input logic         reset_n,
  cond_logic_if.slave bus
);
  logic       cond_ex, exec;
  logic [3:0] flags_q, flags_d;
  cond_check u_check (.cond(cond_e'(bus.Cond)), .flags(flags_q), .cond_ex(cond_ex));
  assign exec         = bus.InstrValid & cond_ex;
  assign bus.CondEx   = cond_ex;
  assign bus.PCSrc    = bus.PCS & exec;
  assign bus.RegWrite = bus.RegW & ~bus.NoWrite & exec;
  assign bus.MemWrite = bus.MemW & exec;
  assign bus.Flags    = flags_q;
  // N,Z and C,V halves load independently, only for instructions that actually execute
  always_comb begin
    flags_d = {exec & bus.FlagW[1] ? bus.ALUFlags[FLAG_N:FLAG_Z] : flags_q[FLAG_N:FLAG_Z],
               exec & bus.FlagW[0] ? bus.ALUFlags[FLAG_C:FLAG_V] : flags_q[FLAG_C:FLAG_V]};
  end
  // flag register; reset overrides any same-cycle update
  always_ff @(posedge clk) begin
    flags_q <= !reset_n ? 4'b0000 : flags_d;
  end
`ifdef COND_PERF_EN
  logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d, squash_cnt_q, squash_cnt_d;
  // saturating counts of executed and squashed valid instructions
  always_comb begin
    exec_cnt_d   = exec && !(&exec_cnt_q) ? exec_cnt_q + 1'b1 : exec_cnt_q;
    squash_cnt_d = bus.InstrValid && !cond_ex && !(&squash_cnt_q) ? squash_cnt_q + 1'b1 : squash_cnt_q;
  end
  // counter registers
  always_ff @(posedge clk) begin
    exec_cnt_q   <= !reset_n ? '0 : exec_cnt_d;
    squash_cnt_q <= !reset_n ? '0 : squash_cnt_d;
  end
  assign bus.ExecCnt   = exec_cnt_q;
  assign bus.SquashCnt = squash_cnt_q;
`else
  assign bus.ExecCnt   = {CNT_W{1'b0}};
  assign bus.SquashCnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: scoreboard bench for cond_logic (COND_PERF_EN optional) against an ARM-level flag model
module tb_cond_logic;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  cond_logic_if #(.CNT_W(CNT_W)) bus ();
  cond_logic #(.CNT_W(CNT_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  typedef struct {
    logic       ce, pc, rw, mw;
    logic [3:0] fl;
    logic [CNT_W-1:0] ec, sc;
  } exp_t;
  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  logic [3:0] m_flags = 4'b0000;
  int m_exec = 0;
  int m_squash = 0;
  function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3];
    z = f[2];
    cy = f[1];
    v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = n == v;
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step(bit rn, bit iv, logic [3:0] c, logic [3:0] alu, logic [1:0] fw,
                      bit pcs, bit rw, bit mw, bit nw);
    exp_t e;
    bit ok;
    @(posedge clk);
    #1;
    reset_n = rn;
    bus.InstrValid = iv;
    bus.Cond = c;
    bus.ALUFlags = alu;
    bus.FlagW = fw;
    bus.PCS = pcs;
    bus.RegW = rw;
    bus.MemW = mw;
    bus.NoWrite = nw;
    ok = cond_ok(c, m_flags);
    e.ce = ok;
    e.pc = pcs && ok && iv;
    e.rw = rw && !nw && ok && iv;
    e.mw = mw && ok && iv;
    e.fl = m_flags;
`ifdef COND_PERF_EN
    e.ec = CNT_W'(m_exec);
    e.sc = CNT_W'(m_squash);
`else
    e.ec = '0;
    e.sc = '0;
`endif
    q.push_back(e);
    if (!rn) begin
      m_flags = 4'b0000;
      m_exec = 0;
      m_squash = 0;
    end else if (iv) begin
      if (ok) begin
        if (fw[1]) m_flags[3:2] = alu[3:2];
        if (fw[0]) m_flags[1:0] = alu[1:0];
        m_exec = m_exec < (1 << CNT_W) - 1 ? m_exec + 1 : m_exec;
      end else
        m_squash = m_squash < (1 << CNT_W) - 1 ? m_squash + 1 : m_squash;
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("CondEx", 32'(bus.CondEx), 32'(e.ce));
      chk("PCSrc", 32'(bus.PCSrc), 32'(e.pc));
      chk("RegWrite", 32'(bus.RegWrite), 32'(e.rw));
      chk("MemWrite", 32'(bus.MemWrite), 32'(e.mw));
      chk("Flags", 32'(bus.Flags), 32'(e.fl));
      chk("ExecCnt", 32'(bus.ExecCnt), 32'(e.ec));
      chk("SquashCnt", 32'(bus.SquashCnt), 32'(e.sc));
    end
  end
  initial begin
    bus.InstrValid = 1'b0;
    bus.Cond = 4'h0;
    bus.ALUFlags = 4'h0;
    bus.FlagW = 2'b00;
    bus.PCS = 1'b0;
    bus.RegW = 1'b0;
    bus.MemW = 1'b0;
    bus.NoWrite = 1'b0;
    step(0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
    step(0, 1, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0);
    step(1, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0);
    step(1, 1, 4'h0, 4'hF, 2'b11, 1, 1, 1, 0);
    step(1, 1, 4'hE, 4'h4, 2'b11, 0, 0, 0, 0);
    step(1, 1, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0);
    step(1, 1, 4'hE, 4'hA, 2'b01, 0, 0, 0, 0);
    step(1, 1, 4'h1, 4'h0, 2'b00, 1, 1, 1, 0);
    step(0, 1, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0);
    step(1, 1, 4'h0, 4'hF, 2'b11, 0, 0, 1, 0);
    step(1, 1, 4'hF, 4'hF, 2'b11, 1, 1, 1, 0);
    step(1, 0, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0);
    step(1, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 1);
    step(1, 1, 4'hE, 4'h9, 2'b01, 0, 0, 0, 0);
    step(1, 1, 4'hE, 4'h8, 2'b10, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 4'hF, 4'h0, 2'b00, 0, 1, 0, 0);
    step(0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
    step(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 39) != 0, $urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)),
           4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 3) == 0);
    repeat (3) @(negedge clk);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
